bram_sdp_multi: RTL and testbench

// NCH independent simple-dual-port RAM channels on one clock. Each channel has one

---
 rtl/bram_sdp_multi_if.sv | 26 ++
 rtl/bram_sdp_multi.sv | 129 ++++++++++++
 tb/tb_bram_sdp_multi.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_sdp_multi_if.sv
// rtl/bram_sdp_multi_if.sv - read/write/clear bus of the multi-channel simple-dual-port RAM
interface bram_sdp_multi_if #(
    parameter int NCH    = 2,
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 18
);
    logic                     clr_req;
    logic                     busy;
    logic [NCH-1:0]           rce;
    logic [NCH*AWIDTH-1:0]    ra;
    logic [NCH*DWIDTH-1:0]    rq;
    logic [NCH-1:0]           rvalid;
    logic [NCH-1:0]           wce;
    logic [NCH*AWIDTH-1:0]    wa;
    logic [NCH*DWIDTH-1:0]    wd;

    modport master (
        output clr_req, rce, ra, wce, wa, wd,
        input  busy, rq, rvalid
    );

    modport slave (
        input  clr_req, rce, ra, wce, wa, wd,
        output busy, rq, rvalid
    );
endinterface

// File: rtl/bram_sdp_multi.sv
// rtl/bram_sdp_multi.sv - NCH independent simple-dual-port RAM channels with zero-fill engine
module bram_sdp_multi #(
    parameter int NCH            = 2,
    parameter int AWIDTH         = 10,
    parameter int DWIDTH         = 18,
    parameter int OREG           = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_sdp_multi_if.slave   bus
);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                busy;

    // Clear-engine state and sweep address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep sequencing: one address per cycle, leave after the last address is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + AWIDTH'(1);
                if (&cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Busy flag is purely a decode of the sweep state
    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    assign bus.busy = busy;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DWIDTH-1:0] mem [DEPTH];
        logic [AWIDTH-1:0] rai, wai, wadr;
        logic [DWIDTH-1:0] wdi, wdat, rdat;
        logic              we, re, bypass;
        logic [DWIDTH-1:0] d1_q;
        logic              v1_q;

        assign rai  = bus.ra[i*AWIDTH +: AWIDTH];
        assign wai  = bus.wa[i*AWIDTH +: AWIDTH];
        assign wdi  = bus.wd[i*DWIDTH +: DWIDTH];

        // The sweep owns the write port while busy; user traffic is dropped
        assign we   = busy | bus.wce[i];
        assign wadr = busy ? cnt_q : wai;
        assign wdat = busy ? '0 : wdi;
        assign re   = bus.rce[i] & ~busy;

        // New-data mode forwards the incoming word on a same-address collision
        assign bypass = (RDW_MODE != 0) && bus.wce[i] && (wai == rai);
        assign rdat   = bypass ? wdi : mem[rai];

        // Memory write port, contents are deliberately not reset
        always_ff @(posedge clk) begin
            if (we) begin
                mem[wadr] <= wdat;
            end
        end

        // First read stage: capture word, hold it when no read is accepted
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                v1_q <= re;
                if (re) begin
                    d1_q <= rdat;
                end
            end
        end

        if (OREG != 0) begin : g_oreg
            logic [DWIDTH-1:0] d2_q;
            logic              v2_q;

            // Optional output register; a sweep starting mid-flight suppresses the pending read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q & ~busy;
                    if (v1_q && !busy) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign bus.rq[i*DWIDTH +: DWIDTH] = d2_q;
            assign bus.rvalid[i]              = v2_q;
        end else begin : g_noreg
            assign bus.rq[i*DWIDTH +: DWIDTH] = d1_q;
            assign bus.rvalid[i]              = v1_q;
        end
    end
endmodule

// File: tb/tb_bram_sdp_multi.sv
// tb/tb_bram_sdp_multi.sv - directed table-driven bench for bram_sdp_multi
module tb_bram_sdp_multi;
    localparam int NCH  = 2;
    localparam int AW   = 4;
    localparam int DW   = 18;
    localparam int OREG = 0;
    localparam int RDW  = 0;
    localparam int COR  = 1;
    localparam int NVEC = 13;

    typedef struct {
        int          ch;
        bit          wr;
        logic [3:0]  wa;
        logic [17:0] wd;
        bit          rd;
        logic [3:0]  ra;
        logic [17:0] exp_q;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    bram_sdp_multi_if #(.NCH(NCH), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    bram_sdp_multi #(
        .NCH(NCH), .AWIDTH(AW), .DWIDTH(DW),
        .OREG(OREG), .RDW_MODE(RDW), .CLEAR_ON_RESET(COR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.clr_req = 1'b0;
        bus.rce     = '0;
        bus.ra      = '0;
        bus.wce     = '0;
        bus.wa      = '0;
        bus.wd      = '0;
    endtask

    task automatic read_both(input int a);
        bus.rce = '1;
        for (int c = 0; c < NCH; c++) bus.ra[c*AW +: AW] = AW'(a);
        tick();
        idle_inputs();
        if (OREG != 0) tick();
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'd16);
    endtask

    initial begin
        logic [NCH*DW-1:0] held;
        logic              bad_rv;
        int                n;

        vecs[0]  = '{0, 1'b1, 4'd5,  18'h2A5A5, 1'b0, 4'd0,  18'h0};
        vecs[1]  = '{0, 1'b0, 4'd0,  18'h0,     1'b1, 4'd5,  18'h2A5A5};
        vecs[2]  = '{1, 1'b1, 4'd5,  18'h00001, 1'b0, 4'd0,  18'h0};
        vecs[3]  = '{0, 1'b0, 4'd0,  18'h0,     1'b1, 4'd5,  18'h2A5A5};
        vecs[4]  = '{1, 1'b0, 4'd0,  18'h0,     1'b1, 4'd5,  18'h00001};
        vecs[5]  = '{0, 1'b1, 4'd7,  18'h11,    1'b0, 4'd0,  18'h0};
        vecs[6]  = '{0, 1'b1, 4'd7,  18'h22,    1'b1, 4'd7,  (RDW != 0) ? 18'h22 : 18'h11};
        vecs[7]  = '{0, 1'b0, 4'd0,  18'h0,     1'b1, 4'd7,  18'h22};
        vecs[8]  = '{1, 1'b0, 4'd0,  18'h0,     1'b1, 4'd7,  18'h0};
        vecs[9]  = '{0, 1'b1, 4'd15, 18'h3FFFF, 1'b0, 4'd0,  18'h0};
        vecs[10] = '{0, 1'b0, 4'd0,  18'h0,     1'b1, 4'd15, 18'h3FFFF};
        vecs[11] = '{0, 1'b1, 4'd0,  18'h00001, 1'b1, 4'd15, 18'h3FFFF};
        vecs[12] = '{0, 1'b0, 4'd0,  18'h0,     1'b1, 4'd0,  18'h00001};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check("reset_rq", 64'(bus.rq), 64'd0);
        check("reset_rvalid", 64'(bus.rvalid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'(COR));

        // T1: automatic sweep after reset release, then everything reads zero
        rst_n = 1'b1;
        count_busy("t1_busy_len");
        for (int a = 0; a < 16; a++) begin
            read_both(a);
            check($sformatf("t1_rvalid_%0d", a), 64'(bus.rvalid), 64'h3);
            check($sformatf("t1_rq_%0d", a), 64'(bus.rq), 64'd0);
        end

        // T2-T4 and address-independence vectors
        for (int k = 0; k < NVEC; k++) begin
            idle_inputs();
            bus.wce[vecs[k].ch]            = vecs[k].wr;
            bus.wa[vecs[k].ch*AW +: AW]    = vecs[k].wa;
            bus.wd[vecs[k].ch*DW +: DW]    = vecs[k].wd;
            bus.rce[vecs[k].ch]            = vecs[k].rd;
            bus.ra[vecs[k].ch*AW +: AW]    = vecs[k].ra;
            tick();
            idle_inputs();
            if (OREG != 0) tick();
            check($sformatf("vec%0d_rvalid", k), 64'(bus.rvalid),
                  vecs[k].rd ? (64'd1 << vecs[k].ch) : 64'd0);
            if (vecs[k].rd)
                check($sformatf("vec%0d_rq", k), 64'(bus.rq[vecs[k].ch*DW +: DW]), 64'(vecs[k].exp_q));
        end

        // rvalid is a single-cycle pulse and rq holds afterwards
        tick();
        check("pulse_rvalid_low", 64'(bus.rvalid), 64'd0);
        check("pulse_rq_hold", 64'(bus.rq[0 +: DW]), 64'h00001);

        // T5: fill, request clear, user traffic during the sweep is dropped
        for (int a = 0; a < 16; a++) begin
            bus.wce = '1;
            bus.wa  = {AW'(a), AW'(a)};
            bus.wd  = {DW'(32'h100 + a), DW'(a + 1)};
            tick();
        end
        idle_inputs();
        read_both(9);
        check("t5_fill_rq", 64'(bus.rq), {28'd0, 18'h109, 18'h0000A});
        held = bus.rq;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("t5_busy_start", 64'(bus.busy), 64'd1);
        bad_rv = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            bus.wce = '1;
            bus.rce = '1;
            bus.wa  = {AW'(3), AW'(3)};
            bus.ra  = {AW'(3), AW'(3)};
            bus.wd  = {18'h3FFFF, 18'h3FFFF};
            if (bus.rvalid != '0) bad_rv = 1'b1;
            tick();
            n++;
        end
        idle_inputs();
        check("t5_busy_len", 64'(n), 64'd16);
        check("t5_no_rvalid", 64'(bad_rv), 64'd0);
        check("t5_rq_hold", 64'(bus.rq), 64'(held));
        for (int a = 0; a < 16; a++) begin
            read_both(a);
            check($sformatf("t5_rq_%0d", a), 64'(bus.rq), 64'd0);
        end

        // T6: reset in the middle of a sweep
        bus.wce = 2'b01;
        bus.wa  = {AW'(0), AW'(2)};
        bus.wd  = {18'h0, 18'h155};
        tick();
        idle_inputs();
        read_both(2);
        check("t6_pre_rq", 64'(bus.rq), {28'd0, 18'h0, 18'h155});
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (8) tick();
        check("t6_busy_mid", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rq", 64'(bus.rq), 64'd0);
        check("t6_rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'(COR));
        tick();
        rst_n = 1'b1;
        count_busy("t6_busy_len");
        read_both(2);
        check("t6_post_rq", 64'(bus.rq), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
